// File: rtl/breadboard_sweep_if.sv
// Sweep output stream: one row index and its function values per beat.
// Latency: none (wires only).
// Backpressure: valid/ready; the master holds row/f stable while valid & !ready.
interface breadboard_sweep_if #(
  parameter int N_IN = 4,
  parameter int N_FN = 10
);
  logic            valid;
  logic            ready;
  logic [N_IN-1:0] row;
  logic [N_FN-1:0] f;

  modport master (output valid, output row, output f, input ready);
  modport slave  (input valid, input row, input f, output ready);
endinterface

// File: rtl/breadboard_sweep.sv
// Runtime-loadable N_FN x 2^N_IN truth tables, evaluated live or by a full row sweep.
// Latency: 1 cycle from in_vec / start / accepted beat to registered row and f.
// Backpressure: sweep beats hold stable until out.ready; no beat is dropped or repeated.
module breadboard_sweep #(
  parameter int N_IN  = 4,
  parameter int N_FN  = 10,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in_vec,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic [(1<<N_IN)-1:0]   cfg_table,
  input  logic                   start,
  breadboard_sweep_if.master     out,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                          state;
  logic [N_FN-1:0][DEPTH-1:0]      tbl;
  logic [N_IN-1:0]                 row_nxt;

  // Column read of every function's table at one row.
  function automatic logic [N_FN-1:0] eval(input logic [N_IN-1:0] r);
    logic [N_FN-1:0] v;
    v = '0;
    for (int j = 0; j < N_FN; j++) v[j] = tbl[j][r];
    return v;
  endfunction

  // Next sweep row; only used when the current row is not the last, so it never wraps.
  always_comb begin
    row_nxt = out.row + 1'b1;
  end

  // Single FSM: table writes, direct evaluation, and the handshaked row sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tbl       <= '0;
      out.valid <= 1'b0;
      out.row   <= '0;
      out.f     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Direct mode sees the tables as they were before a same-edge write.
          out.row   <= in_vec;
          out.f     <= eval(in_vec);
          out.valid <= 1'b0;
          if (cfg_we) begin
            // A write wins over start; out-of-range selects are dropped.
            if (int'(cfg_sel) < N_FN) tbl[cfg_sel] <= cfg_table;
          end else if (start) begin
            state     <= S_SWEEP;
            out.row   <= '0;
            out.f     <= eval('0);
            out.valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (out.valid && out.ready) begin
            if (out.row == LAST_ROW) begin
              out.valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              out.row <= row_nxt;
              out.f   <= eval(row_nxt);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_breadboard_sweep.sv
// Directed bench for breadboard_sweep: sweeps, stalls, direct mode, config corners, async reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_breadboard_sweep;

  localparam int N_IN  = 4;
  localparam int N_FN  = 10;
  localparam int SEL_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IN-1:0]   in_vec;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [15:0]       cfg_table;
  logic              start;
  logic              busy;
  logic              done;

  breadboard_sweep_if #(.N_IN(N_IN), .N_FN(N_FN)) sw ();

  breadboard_sweep #(.N_IN(N_IN), .N_FN(N_FN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_vec    (in_vec),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_table (cfg_table),
    .start     (start),
    .out       (sw.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected table contents, updated only by writes the design should accept.
  logic [15:0] mt [N_FN];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [N_FN-1:0] mev(input int r);
    logic [N_FN-1:0] v;
    v = '0;
    for (int j = 0; j < N_FN; j++) v[j] = mt[j][r];
    return v;
  endfunction

  task automatic load(input int sel, input logic [15:0] t, input bit with_start);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel[SEL_W-1:0];
    cfg_table = t;
    start     = with_start;
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
    if (sel < N_FN) mt[sel] = t;
    if (with_start) begin
      check("we_start_busy", busy, 1'b0);
      check("we_start_valid", sw.valid, 1'b0);
      @(negedge clk);
      check("we_start_busy2", busy, 1'b0);
    end
  endtask

  // One full sweep. exp0 is the hand-written column for function 0.
  task automatic run_sweep(input string tag, input bit stall, input bit restart,
                           input bit cfg_during, input logic [15:0] exp0);
    int n, exp_row, beats, done_n, st_cnt, stalls;
    n = 0; exp_row = 0; beats = 0; done_n = 0; st_cnt = 0; stalls = 0;
    @(negedge clk);
    start    = 1'b1;
    sw.ready = 1'b1;
    if (cfg_during) begin
      cfg_sel   = '0;
      cfg_table = 16'hFFFF;
    end
    while (n < 60 && done_n == 0) begin
      @(negedge clk);
      n++;
      if (!restart) start = 1'b0;
      if (cfg_during) cfg_we = 1'b1;
      if (done) begin
        done_n = n;
        check({tag, "_done_novalid"}, sw.valid, 1'b0);
      end else if (sw.valid) begin
        check({tag, "_row"}, sw.row, exp_row);
        check({tag, "_busy"}, busy, 1'b1);
        if (exp_row < 16) begin
          check({tag, "_f"}, sw.f, mev(exp_row));
          check({tag, "_f0"}, sw.f[0], exp0[exp_row]);
        end
        if (stall && (exp_row == 3 || exp_row == 7) && st_cnt < 2) begin
          sw.ready = 1'b0;
          st_cnt++;
          stalls++;
        end else begin
          sw.ready = 1'b1;
          st_cnt = 0;
          exp_row++;
          beats++;
        end
      end
    end
    check({tag, "_beats"}, beats, 16);
    check({tag, "_done_cycle"}, done_n, stall ? 21 : 17);
    // The DONE state sees start/cfg_we still high and must ignore both.
    @(negedge clk);
    start    = 1'b0;
    cfg_we   = 1'b0;
    sw.ready = 1'b1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_no_restart"}, busy, 1'b0);
    check({tag, "_no_redone"}, done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_vec = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_table = '0;
    start = 1'b0; sw.ready = 1'b0;
    for (int j = 0; j < N_FN; j++) mt[j] = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", sw.valid, 1'b0);
    check("rst_row", sw.row, 4'd0);
    check("rst_f", sw.f, 10'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;

    // Basic sweep over a single loaded function.
    load(0, 16'hEE21, 1'b0);
    run_sweep("sweep", 1'b0, 1'b0, 1'b0, 16'hEE21);

    // Two 2-cycle stalls on rows 3 and 7.
    run_sweep("stall", 1'b1, 1'b0, 1'b0, 16'hEE21);

    // Direct mode: one-cycle latency, no valid.
    @(negedge clk);
    in_vec = 4'b0101;
    @(negedge clk);
    in_vec = 4'b1000;
    check("direct_row5", sw.row, 4'd5);
    check("direct_f0_5", sw.f[0], 1'b1);
    check("direct_valid5", sw.valid, 1'b0);
    @(negedge clk);
    check("direct_row8", sw.row, 4'd8);
    check("direct_f0_8", sw.f[0], 1'b0);
    check("direct_f_8", sw.f, 10'd0);
    check("direct_valid8", sw.valid, 1'b0);

    // Out-of-range selects must not touch any table.
    load(10, 16'hFFFF, 1'b0);
    load(12, 16'hFFFF, 1'b0);
    // start and cfg_we held through SWEEP and DONE are ignored.
    run_sweep("ignore", 1'b0, 1'b1, 1'b1, 16'hEE21);
    run_sweep("after_ignore", 1'b0, 1'b0, 1'b0, 16'hEE21);

    // Write together with start: write lands, no sweep begins.
    load(1, 16'h8001, 1'b1);
    load(9, 16'h0F0F, 1'b0);
    run_sweep("multi", 1'b0, 1'b0, 1'b0, 16'hEE21);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    start    = 1'b1;
    sw.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !(sw.valid && sw.row == 4'd7); i++) @(negedge clk);
    check("mid_row7", sw.row, 4'd7);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", sw.valid, 1'b0);
    check("arst_row", sw.row, 4'd0);
    check("arst_f", sw.f, 10'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < N_FN; j++) mt[j] = '0;
    run_sweep("cleared", 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/breadboard_sweep.md
# breadboard_sweep

Parametrised, clocked successor to the team's 4-input, 10-function combinational breadboard. Holds N_FN runtime-loadable truth tables over N_IN inputs and evaluates them into a registered output vector, either directly from a live input vector or by an autonomous sweep of every input combination. The sweep streams one row per accepted beat over a valid/ready handshake and replaces the testbench loop that previously enumerated rows.

## Interface
- N_IN, default 4: number of Boolean inputs; row index width; table depth is 2^N_IN.
- N_FN, default 10: number of independent functions (output bits).
- SEL_W, default 4: width of cfg_sel; must satisfy 2^SEL_W >= N_FN.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high; clears all state including tables.
- in_vec  in  N_IN  live input row for direct mode; bit N_IN-1 is MSB (the "w" position).
- cfg_we  in  1  table write strobe.
- cfg_sel  in  SEL_W  function index to write.
- cfg_table  in  2^N_IN  truth table; bit k is function value for row k.
- start  in  1  single-cycle sweep request.
- out_ready  in  1  consumer accepts current sweep beat.
- out_valid  out  1  sweep beat present.
- out_row  out  N_IN  row index of out_f.
- out_f  out  N_FN  function values; bit j = table[j][out_row].
- busy  out  1  high in SWEEP and DONE.
- done  out  1  one-cycle pulse ending a sweep.

## Operation
- Storage: N_FN x 2^N_IN flops. Reset clears all to 0.
- Reset values: out_valid=0, out_row=0, out_f=0, busy=0, done=0, state IDLE, row counter 0.
- Config write: accepted only in IDLE with cfg_we=1 and cfg_sel < N_FN; table[cfg_sel] <= cfg_table at that edge. cfg_sel >= N_FN: ignored, no table changes. cfg_we outside IDLE: ignored.
- States: IDLE, SWEEP, DONE.
- IDLE: each edge out_row <= in_vec, out_f <= eval(in_vec) using tables as they were before that edge; out_valid=0.
- IDLE -> SWEEP: start=1 and cfg_we=0. If cfg_we=1 in the same cycle, the write is accepted and start is dropped (stays IDLE). At the transition edge out_row <= 0, out_f <= eval(0), out_valid <= 1.
- SWEEP: beat transfers on an edge where out_valid & out_ready. On a transfer with out_row < 2^N_IN-1, out_row <= out_row+1 and out_f <= eval(out_row+1). Without a transfer, out_row/out_f/out_valid hold stable.
- SWEEP -> DONE: transfer of row 2^N_IN-1; out_valid <= 0, done <= 1. Row counter never wraps visibly; no extra beat is produced.
- DONE -> IDLE: unconditional after one cycle; done <= 0.
- start in SWEEP or DONE: ignored. in_vec ignored outside IDLE.
- Reset mid-sweep: immediate return to reset values; tables also cleared. Tables must be reloaded before use.

## Timing
- Direct-mode latency: 1 cycle (in_vec at edge n -> out_f valid after edge n).
- Sweep: start at edge s -> row 0 valid after s. With out_ready held 1, row k is presented after edge s+k; done=1 after edge s+2^N_IN; IDLE after s+2^N_IN+1.
- Minimum sweep-to-sweep spacing: 2^N_IN+2 cycles.
- Throughput: one beat per cycle under continuous out_ready.
- done and out_valid never high together.

## Test plan
- Load cfg_sel=0, cfg_table=16'hEE21 (N_IN=4); start, out_ready=1 -> 16 beats, rows 0..15, out_f[0] = 1,0,0,0,0,1,0,0,0,1,1,1,0,1,1,1; done pulses exactly once one cycle after row 15; other out_f bits 0.
- Backpressure: same sweep, out_ready low on rows 3 and 7 for 2 cycles each -> out_row/out_f stable while stalled, no rows skipped or repeated, done arrives 4 cycles later than unstalled run.
- Direct mode: tables loaded, drive in_vec=4'b0101 then 4'b1000 on consecutive cycles -> out_f[0]=1 then 0, one cycle later each; out_valid stays 0.
- Config corner cases: cfg_sel=12 (>= N_FN) write -> no table changes; cfg_we during SWEEP -> table unchanged after sweep; cfg_we and start together in IDLE -> write lands, busy stays 0.
- start re-asserted during SWEEP and DONE -> ignored; exactly 16 beats, one done.
- Async reset asserted after row 6 of a sweep -> all outputs 0 without waiting for clk; subsequent sweep with no reload gives out_f=0 on all 16 rows.
